// File: rtl/c3lib_en_debounce_lcell.sv
// Debounced, hysteresis-qualified enable for the NAND2 gating lcell enable leg.
// Define C3LIB_EN_DEBOUNCE_SYNC_EN to insert a 2-flop synchronizer on en_async.
module c3lib_en_debounce_lcell #(
    parameter int   CNT_WIDTH = 4,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_async,
    input  logic [CNT_WIDTH-1:0] hold_cnt,
    output logic                 en_out,
    output logic                 evt_pulse,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RISE_WAIT = 2'd1,
        ST_ON        = 2'd2,
        ST_FALL_WAIT = 2'd3
    } state_t;

    localparam state_t RST_STATE = RST_VAL ? ST_ON : ST_OFF;

    logic s_q;

`ifdef C3LIB_EN_DEBOUNCE_SYNC_EN
    logic sync1_q;

    // Flops reset to RST_VAL so the FSM sees no request right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= RST_VAL;
            s_q     <= RST_VAL;
        end else begin
            sync1_q <= en_async;
            s_q     <= sync1_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) s_q <= RST_VAL;
        else     s_q <= en_async;
    end
`endif

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 en_q;
    logic                 evt_q;

    // Saturating increment; the >= compare keeps a saturated count qualifying.
    assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            en_q    <= RST_VAL;
            evt_q   <= 1'b0;
        end else begin
            evt_q <= 1'b0;
            case (state_q)
                ST_OFF: begin
                    if (s_q) begin
                        state_q <= ST_RISE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                ST_RISE_WAIT: begin
                    // Abort is checked first so it wins over a same-cycle qualify.
                    if (!s_q) begin
                        state_q <= ST_OFF;
                    end else if (cnt_q >= hold_cnt) begin
                        state_q <= ST_ON;
                        en_q    <= 1'b1;
                        evt_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_ON: begin
                    if (!s_q) begin
                        state_q <= ST_FALL_WAIT;
                        cnt_q   <= '0;
                    end
                end
                ST_FALL_WAIT: begin
                    if (s_q) begin
                        state_q <= ST_ON;
                    end else if (cnt_q >= hold_cnt) begin
                        state_q <= ST_OFF;
                        en_q    <= 1'b0;
                        evt_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= RST_STATE;
                    cnt_q   <= '0;
                    en_q    <= RST_VAL;
                end
            endcase
        end
    end

    assign en_out    = en_q;
    assign evt_pulse = evt_q;
    assign busy      = (state_q == ST_RISE_WAIT) || (state_q == ST_FALL_WAIT);

endmodule

// File: tb/tb_c3lib_en_debounce_lcell.sv
// Directed bench for c3lib_en_debounce_lcell; adapts the input-stage latency to the build.
module tb_c3lib_en_debounce_lcell;

`ifdef C3LIB_EN_DEBOUNCE_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic       clk = 1'b0;
    logic       rst, rst1, en_a, en1;
    logic [3:0] hold, hold1;
    logic       eo0, ev0, bz0, eo1, ev1, bz1;

    int checks = 0;
    int failures = 0;
    int pulses0 = 0;
    int pulses1 = 0;
    int busy_seen = 0;

    always #5 clk = ~clk;

    c3lib_en_debounce_lcell #(.CNT_WIDTH(4), .RST_VAL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en_async(en_a), .hold_cnt(hold),
        .en_out(eo0), .evt_pulse(ev0), .busy(bz0)
    );

    c3lib_en_debounce_lcell #(.CNT_WIDTH(4), .RST_VAL(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .en_async(en1), .hold_cnt(hold1),
        .en_out(eo1), .evt_pulse(ev1), .busy(bz1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ev0) pulses0++;
        if (ev1) pulses1++;
        if (bz0) busy_seen++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_rise;
        int t_fast;
        logic prev;
        logic nxt;
        int widths [2];

        rst = 1'b1; rst1 = 1'b1; en_a = 1'b0; en1 = 1'b1; hold = 4'd3; hold1 = 4'd3;
        repeat (3) tick();
        chk("rst0_en", eo0, 0);
        chk("rst0_busy", bz0, 0);
        chk("rst0_evt", ev0, 0);
        chk("rst1_en", eo1, 1);
        chk("rst1_busy", bz1, 0);
        chk("rst1_evt", ev1, 0);
        rst = 1'b0; rst1 = 1'b0;

        // Idle after reset: no pulses
        pulses0 = 0; pulses1 = 0;
        repeat (20) tick();
        chk("idle0_pulses", pulses0, 0);
        chk("idle1_pulses", pulses1, 0);
        chk("idle0_en", eo0, 0);
        chk("idle1_en", eo1, 1);

        // Held rise then held fall, hold=3
        t_rise = L + 1 + 3;
        en_a = 1'b1;
        for (int k = 0; k <= t_rise + 2; k++) begin
            tick();
            chk($sformatf("rise_en_k%0d", k), eo0, (k >= t_rise));
            chk($sformatf("rise_evt_k%0d", k), ev0, (k == t_rise));
            chk($sformatf("rise_busy_k%0d", k), bz0, (k >= L && k < t_rise));
        end
        en_a = 1'b0;
        for (int k = 0; k <= t_rise + 2; k++) begin
            tick();
            chk($sformatf("fall_en_k%0d", k), eo0, !(k >= t_rise));
            chk($sformatf("fall_evt_k%0d", k), ev0, (k == t_rise));
            chk($sformatf("fall_busy_k%0d", k), bz0, (k >= L && k < t_rise));
        end

        // Glitches of 2 and hold+1 cycles must be filtered
        widths[0] = 2; widths[1] = 4;
        foreach (widths[i]) begin
            pulses0 = 0; busy_seen = 0;
            en_a = 1'b1;
            repeat (widths[i]) tick();
            en_a = 1'b0;
            repeat (12) tick();
            chk($sformatf("glitch%0d_en", widths[i]), eo0, 0);
            chk($sformatf("glitch%0d_pulses", widths[i]), pulses0, 0);
            chk($sformatf("glitch%0d_busy", widths[i]), (busy_seen != 0), 1);
        end

        // hold=0, toggle every 4 cycles
        hold = 4'd0;
        t_fast = L + 1;
        prev = 1'b0;
        for (int t = 0; t < 4; t++) begin
            nxt = (t % 2 == 0);
            en_a = nxt;
            for (int k = 0; k < 4; k++) begin
                tick();
                chk($sformatf("fast_en_t%0d_k%0d", t, k), eo0, (k >= t_fast) ? nxt : prev);
                chk($sformatf("fast_evt_t%0d_k%0d", t, k), ev0, (k == t_fast));
            end
            prev = nxt;
        end

        // Lower hold_cnt mid-wait below the current count
        hold = 4'd15;
        en_a = 1'b1;
        for (int k = 0; k <= L + 5; k++) tick();
        chk("midwait_busy", bz0, 1);
        chk("midwait_en_pre", eo0, 0);
        hold = 4'd2;
        tick();
        chk("midwait_en_post", eo0, 1);
        chk("midwait_evt_post", ev0, 1);
        en_a = 1'b0; hold = 4'd3;
        repeat (12) tick();
        chk("midwait_fall_en", eo0, 0);

        // Reset during FALL_WAIT on the RST_VAL=1 instance
        en1 = 1'b0;
        for (int k = 0; k <= L; k++) tick();
        chk("fw_busy", bz1, 1);
        chk("fw_en", eo1, 1);
        rst1 = 1'b1; en1 = 1'b1;
        pulses1 = 0;
        tick();
        chk("fwrst_en", eo1, 1);
        chk("fwrst_busy", bz1, 0);
        chk("fwrst_evt", ev1, 0);
        rst1 = 1'b0;
        repeat (10) tick();
        chk("fwrst_pulses", pulses1, 0);
        chk("fwrst_en_after", eo1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
